ysyx_25060173_exec_ctrl: RTL and testbench

- Multi-cycle sequencer that drives the single-cycle core datapath: fetches each instruction over a valid/ready memory port, presents it to the decoder/ALU, and sequences the load/store handshake.
- Gates the PC and register-file write enables into a single commit pulse per instruction.
- Halts on ebreak and traps to a sticky fault state on bus error or response timeout.
- Sits between the core and the instruction/data memory interfaces.

---
 rtl/ysyx_25060173_exec_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_25060173_exec_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060173_exec_ctrl.sv
// Multi-cycle execution sequencer for the single-cycle core datapath.
// Fetches one instruction per pass over a valid/ready port, holds it for the
// decoder, sequences the load/store handshake and emits one commit pulse per
// retired instruction. Ebreak parks the sequencer in a halt state; bus errors
// and response timeouts park it in a sticky fault state until reset.
module ysyx_25060173_exec_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             is_mem,
    input  logic             is_ebreak,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [31:0]      ifu_req_addr,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_data,
    input  logic             ifu_rsp_err,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,
    output logic             commit,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IREQ  = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_DREQ  = 3'd3,
        S_DWAIT = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [1:0]  CODE_IFETCH  = 2'd1;
    localparam logic [1:0]  CODE_DATA    = 2'd2;
    localparam logic [1:0]  CODE_TIMEOUT = 2'd3;

    // Timeout limit in the counter's own width; TIMEOUT is bounded to 16 bits.
    localparam logic [15:0] TMO_LIMIT    = 16'(TIMEOUT);

    state_t      state_r;
    logic [15:0] tmo_cnt_r;
    logic [15:0] tmo_next_s;
    logic        tmo_hit_s;
    logic        running_s;

    // The wait counter value after this cycle, and whether that reaches the limit.
    always_comb begin
        tmo_next_s = tmo_cnt_r + 16'd1;
        tmo_hit_s  = (tmo_next_s == TMO_LIMIT);
    end

    // Request, status and commit outputs decoded from the registered state.
    // commit must coincide with the EXEC/DWAIT cycle the core acts on, so it
    // is decoded combinationally from state plus the qualifying inputs.
    always_comb begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        inst_valid    = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;
        commit        = 1'b0;
        running_s     = 1'b1;
        ifu_req_addr  = pc;
        case (state_r)
            S_IREQ: begin
                ifu_req_valid = 1'b1;
            end
            S_IWAIT: begin
                ifu_req_valid = 1'b0;
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                // Ebreak retires even when the decoder also flags a memory op.
                commit     = is_ebreak | ~is_mem;
            end
            S_DREQ: begin
                inst_valid    = 1'b1;
                lsu_req_valid = 1'b1;
            end
            S_DWAIT: begin
                inst_valid = 1'b1;
                commit     = lsu_rsp_valid & ~lsu_rsp_err;
            end
            S_HALT: begin
                halted    = 1'b1;
                running_s = 1'b0;
            end
            S_FAULT: begin
                fault     = 1'b1;
                running_s = 1'b0;
            end
            default: begin
                // Unreachable encodings behave like a fault: no requests, no commit.
                fault     = 1'b1;
                running_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: state, held instruction, response wait counter, fault code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IREQ;
            inst       <= 32'd0;
            tmo_cnt_r  <= 16'd0;
            fault_code <= 2'd0;
        end else begin
            case (state_r)
                S_IREQ: begin
                    // Any response seen here is stale by construction and ignored.
                    if (ifu_req_ready) begin
                        state_r   <= S_IWAIT;
                        tmo_cnt_r <= 16'd0;
                    end
                end
                S_IWAIT: begin
                    // A response in the limit cycle still wins over the timeout.
                    if (ifu_rsp_valid) begin
                        if (ifu_rsp_err) begin
                            state_r    <= S_FAULT;
                            fault_code <= CODE_IFETCH;
                        end else begin
                            inst    <= ifu_rsp_data;
                            state_r <= S_EXEC;
                        end
                    end else if (tmo_hit_s) begin
                        state_r    <= S_FAULT;
                        fault_code <= CODE_TIMEOUT;
                    end else begin
                        tmo_cnt_r <= tmo_next_s;
                    end
                end
                S_EXEC: begin
                    if (is_ebreak) begin
                        state_r <= S_HALT;
                    end else if (is_mem) begin
                        state_r <= S_DREQ;
                    end else begin
                        state_r <= S_IREQ;
                    end
                end
                S_DREQ: begin
                    if (lsu_req_ready) begin
                        state_r   <= S_DWAIT;
                        tmo_cnt_r <= 16'd0;
                    end
                end
                S_DWAIT: begin
                    if (lsu_rsp_valid) begin
                        if (lsu_rsp_err) begin
                            state_r    <= S_FAULT;
                            fault_code <= CODE_DATA;
                        end else begin
                            state_r <= S_IREQ;
                        end
                    end else if (tmo_hit_s) begin
                        state_r    <= S_FAULT;
                        fault_code <= CODE_TIMEOUT;
                    end else begin
                        tmo_cnt_r <= tmo_next_s;
                    end
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                S_FAULT: begin
                    state_r <= S_FAULT;
                end
                default: begin
                    state_r <= S_FAULT;
                end
            endcase
        end
    end

    // Free-running cycle counter (frozen once parked) and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (running_s) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (commit) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25060173_exec_ctrl.sv
// Scoreboard bench for the execution sequencer. The driver plays both memory
// ports on a planned per-instruction schedule and, from the planned wait
// counts, predicts the cycle at which each commit must appear; a separate
// monitor pops those predictions whenever the DUT pulses commit.
module tb_ysyx_25060173_exec_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 8;
    localparam int CMOD = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   pc = 32'd0;
    logic          is_mem = 1'b0;
    logic          is_ebreak = 1'b0;
    logic          ifu_req_valid;
    logic          ifu_req_ready = 1'b0;
    logic [31:0]   ifu_req_addr;
    logic          ifu_rsp_valid = 1'b0;
    logic [31:0]   ifu_rsp_data = 32'd0;
    logic          ifu_rsp_err = 1'b0;
    logic [31:0]   inst;
    logic          inst_valid;
    logic          lsu_req_valid;
    logic          lsu_req_ready = 1'b0;
    logic          lsu_rsp_valid = 1'b0;
    logic          lsu_rsp_err = 1'b0;
    logic          commit;
    logic          halted;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] instret_cnt;

    ysyx_25060173_exec_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .is_mem(is_mem), .is_ebreak(is_ebreak),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .inst(inst), .inst_valid(inst_valid), .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_err(lsu_rsp_err), .commit(commit), .halted(halted), .fault(fault),
        .fault_code(fault_code), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        int          cyc;
        int          ret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          t_model = 0;
    int          ret_model = 0;
    logic [31:0] last_inst = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every commit pulse must match the next prediction.
    always @(negedge clk) begin
        if (!reset && commit) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 64'(commit), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_inst", 64'(inst), 64'(mon_e.inst));
                chk("commit_cycle", 64'(cycle_cnt), 64'(mon_e.cyc % CMOD));
                chk("commit_instret", 64'(instret_cnt), 64'(mon_e.ret % CMOD));
                chk("commit_inst_valid", 64'(inst_valid), 64'd1);
            end
        end
    end

    // Advance to just after the next rising edge; decoder flags get junk
    // outside EXEC, where the sequencer must ignore them.
    task automatic cyc_end();
        @(posedge clk);
        #1;
        is_mem    = 1'($urandom_range(0, 1));
        is_ebreak = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        chk("pending_before_reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        reset = 1'b1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        t_model = 0; ret_model = 0; last_inst = 32'd0;
    endtask

    // One stalled IREQ cycle used to inspect the counters between instructions.
    task automatic idle_check(input string tag);
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
        #3;
        chk({tag, "_cycle"}, 64'(cycle_cnt), 64'(t_model % CMOD));
        chk({tag, "_instret"}, 64'(instret_cnt), 64'(ret_model % CMOD));
        chk({tag, "_ifu_valid"}, 64'(ifu_req_valid), 64'd1);
        chk({tag, "_inst"}, 64'(inst), 64'(last_inst));
        cyc_end();
        t_model++;
    endtask

    // kind 0 = ALU, 1 = load/store, 2 = ebreak (issued with is_mem also set).
    task automatic run_instr(input logic [31:0] a, input logic [31:0] d, input int kind,
                             input int iw, input int rw, input int dw, input int sw,
                             input bit spur);
        exp_t e;
        int   dur;
        dur = iw + rw + 3 + ((kind == 1) ? (dw + sw + 2) : 0);
        e.inst = d; e.cyc = t_model + dur - 1; e.ret = ret_model;
        exp_q.push_back(e);
        ret_model++;
        t_model += dur;
        pc = a; ifu_rsp_err = 1'b0; lsu_rsp_err = 1'b0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
        for (int k = 0; k < iw; k++) begin
            ifu_req_ready = 1'b0; ifu_rsp_valid = spur; ifu_rsp_data = ~d;
            #3;
            chk("ireq_valid_hold", 64'(ifu_req_valid), 64'd1);
            chk("ireq_addr_hold", 64'(ifu_req_addr), 64'(a));
            cyc_end();
        end
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0;
        #3;
        chk("ireq_valid", 64'(ifu_req_valid), 64'd1);
        chk("ireq_addr", 64'(ifu_req_addr), 64'(a));
        cyc_end();
        ifu_req_ready = 1'b0;
        for (int k = 0; k < rw; k++) begin
            ifu_rsp_valid = 1'b0;
            cyc_end();
        end
        ifu_rsp_valid = 1'b1; ifu_rsp_data = d;
        cyc_end();
        ifu_rsp_valid = 1'b0; ifu_rsp_data = $urandom;
        last_inst = d;
        is_ebreak = (kind == 2);
        is_mem    = (kind != 0);
        #3;
        chk("exec_inst_valid", 64'(inst_valid), 64'd1);
        chk("exec_no_lsu", 64'(lsu_req_valid), 64'd0);
        cyc_end();
        if (kind == 1) begin
            for (int k = 0; k < dw; k++) begin
                lsu_req_ready = 1'b0;
                #3;
                chk("dreq_valid_hold", 64'(lsu_req_valid), 64'd1);
                cyc_end();
            end
            lsu_req_ready = 1'b1;
            #3;
            chk("dreq_valid", 64'(lsu_req_valid), 64'd1);
            cyc_end();
            lsu_req_ready = 1'b0;
            for (int k = 0; k < sw; k++) begin
                lsu_rsp_valid = 1'b0;
                cyc_end();
            end
            lsu_rsp_valid = 1'b1;
            cyc_end();
            lsu_rsp_valid = 1'b0;
        end
    endtask

    // Parked-state checks: no requests, no commit, counters frozen.
    task automatic park_check(input bit exp_halt, input logic [1:0] code);
        for (int k = 0; k < 3; k++) begin
            ifu_req_ready = 1'b1; lsu_req_ready = 1'b1;
            ifu_rsp_valid = 1'($urandom_range(0, 1)); lsu_rsp_valid = 1'($urandom_range(0, 1));
            #3;
            chk("park_halted", 64'(halted), 64'(exp_halt));
            chk("park_fault", 64'(fault), 64'(!exp_halt));
            chk("park_code", 64'(fault_code), 64'(code));
            chk("park_ifu_valid", 64'(ifu_req_valid), 64'd0);
            chk("park_lsu_valid", 64'(lsu_req_valid), 64'd0);
            chk("park_commit", 64'(commit), 64'd0);
            chk("park_cycle", 64'(cycle_cnt), 64'(t_model % CMOD));
            chk("park_instret", 64'(instret_cnt), 64'(ret_model % CMOD));
            chk("park_inst", 64'(inst), 64'(last_inst));
            cyc_end();
        end
        ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;
        ifu_req_ready = 1'b0; lsu_req_ready = 1'b0;
    endtask

    // mode 1 ifetch error, 2 data error, 3 ifetch timeout, 4 data timeout.
    task automatic run_fault(input int mode, input logic [31:0] a, input logic [31:0] d);
        pc = a; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
        lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0; lsu_req_ready = 1'b0;
        ifu_req_ready = 1'b1;
        cyc_end();
        ifu_req_ready = 1'b0;
        if (mode == 1) begin
            ifu_rsp_valid = 1'b1; ifu_rsp_err = 1'b1; ifu_rsp_data = d;
            cyc_end();
            t_model += 2;
        end else if (mode == 3) begin
            repeat (TMO) cyc_end();
            t_model += 1 + TMO;
        end else begin
            ifu_rsp_valid = 1'b1; ifu_rsp_data = d;
            cyc_end();
            ifu_rsp_valid = 1'b0;
            last_inst = d;
            is_mem = 1'b1; is_ebreak = 1'b0;
            cyc_end();
            lsu_req_ready = 1'b1;
            cyc_end();
            lsu_req_ready = 1'b0;
            if (mode == 2) begin
                lsu_rsp_valid = 1'b1; lsu_rsp_err = 1'b1;
                cyc_end();
                t_model += 5;
            end else begin
                repeat (TMO) cyc_end();
                t_model += 4 + TMO;
            end
        end
        ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
        lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
        park_check(1'b0, (mode == 1) ? 2'd1 : (mode == 2) ? 2'd2 : 2'd3);
    endtask

    // Asynchronous reset pulse while waiting for a fetch response.
    task automatic reset_mid_iwait(input logic [31:0] a);
        pc = a; ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b1;
        cyc_end();
        ifu_req_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_commit", 64'(commit), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_code", 64'(fault_code), 64'd0);
        chk("rst_cycle", 64'(cycle_cnt), 64'd0);
        chk("rst_instret", 64'(instret_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t_model = 0; ret_model = 0; last_inst = 32'd0;
        idle_check("post_reset");
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        return r & 32'hFFFF_FFFC;
    endfunction

    initial begin
        do_reset();
        // Zero-wait ALU stream: commit every third cycle.
        for (int i = 0; i < 4; i++) run_instr(32'h8000_0000, 32'h0010_0093, 0, 0, 0, 0, 0, 1'b0);
        idle_check("after_four");
        // Fetch request stalled for five cycles, with stale responses ignored.
        run_instr(32'h8000_0000, 32'h0020_0113, 0, 5, 0, 0, 0, 1'b1);
        // Store with delayed accept and delayed response.
        run_instr(32'h8000_0008, 32'h00a1_2023, 1, 0, 0, 1, 2, 1'b0);
        // Responses in the last cycle before the timeout limit.
        run_instr(32'h8000_000c, 32'h0001_2083, 1, 0, TMO - 1, 0, TMO - 1, 1'b0);
        // Randomized mix; the 8-bit counters wrap during this run.
        for (int i = 0; i < 40; i++) begin
            run_instr(rand_pc(), $urandom, $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, TMO - 1),
                      $urandom_range(0, 3), $urandom_range(0, TMO - 1),
                      1'($urandom_range(0, 1)));
        end
        // Ebreak with is_mem also set: commit, then halt.
        run_instr(rand_pc(), 32'h0010_0073, 2, 0, 1, 0, 0, 1'b0);
        park_check(1'b1, 2'd0);

        do_reset();
        run_instr(rand_pc(), $urandom, 0, 1, 2, 0, 0, 1'b0);
        run_fault(3, rand_pc(), $urandom);

        do_reset();
        run_instr(rand_pc(), $urandom, 0, 0, 0, 0, 0, 1'b0);
        run_fault(1, rand_pc(), $urandom);

        do_reset();
        run_instr(rand_pc(), $urandom, 1, 0, 1, 0, 1, 1'b0);
        reset_mid_iwait(rand_pc());
        run_instr(rand_pc(), $urandom, 0, 0, 0, 0, 0, 1'b0);
        run_instr(rand_pc(), $urandom, 1, 1, 0, 2, 0, 1'b0);
        run_fault(2, rand_pc(), $urandom);

        do_reset();
        run_instr(rand_pc(), $urandom, 1, 0, 0, 0, 0, 1'b0);
        run_fault(4, rand_pc(), $urandom);

        chk("pending_at_end", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
